// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the stalling memory responder.
package mem_resp_pkg;

  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    BUSY
  } state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shift form.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Expand byte strobes into a per-bit write mask.
  function automatic data_t strb_to_mask(input strb_t strb);
    data_t mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  // One Galois LFSR step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/mem_stall_responder_lfsr.sv
// 16-bit Galois LFSR that only moves when told to, so the stall pattern
// is a pure function of how many transactions have been accepted.
module stall_lfsr
  import mem_resp_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // Next LFSR value: hold unless an accept asks for a step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR state register, reloaded with the seed on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mem_stall_responder.sv
// req/gnt memory responder: word SRAM with byte strobes, pseudo-random grant
// stalls and a fixed response latency, with an rvalid/err response channel.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int          Depth       = 1 << 20,
  parameter logic [31:0] AddrBase    = 32'h80000000,
  parameter int          ReadLatency = 1,
  parameter int          MaxStall    = 3,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_en_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  strb_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int LatW   = 3;
  localparam int StallW = 4;

  state_e              state_q, state_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic                rsp_read_q, rsp_read_d;
  logic                rsp_err_q, rsp_err_d;
  data_t               mem_rdata_q;

  logic [15:0]         lfsr;
  logic                accept;
  logic                idle_like;
  logic [StallW-1:0]   stall_pick;
  addr_t               idx;
  logic                in_range;
  logic [IdxW-1:0]     widx;
  data_t               wmask;
  logic                unused_lfsr_hi;

  data_t               mem [Depth];

  // Only the low nibble of the LFSR picks the stall length.
  assign unused_lfsr_hi = ^lfsr[15:4];

  // Word index relative to the window base; wrap-around puts addresses
  // below the base far out of range.
  assign idx      = (addr_i - AddrBase) >> 2;
  assign in_range = idx < addr_t'(Depth);
  assign widx     = idx[IdxW-1:0];
  assign wmask    = strb_to_mask(strb_i);

  function automatic logic [StallW-1:0] stall_amount(input logic [3:0] rnd);
    int picked;
    picked = int'(rnd) % (MaxStall + 1);
    return StallW'(picked);
  endfunction

  stall_lfsr #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .advance_i(accept),
    .lfsr_o   (lfsr)
  );

  // Stall length for a request seen now; zero when injection is off.
  always_comb begin
    stall_pick = '0;
    if (stall_en_i && (MaxStall > 0)) begin
      stall_pick = stall_amount(lfsr[3:0]);
    end
  end

  // Handshake FSM; the final BUSY cycle doubles as IDLE so a new request
  // can be granted alongside the response. Outputs stay quiet in reset.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    gnt_o       = 1'b0;
    rvalid_o    = 1'b0;
    accept      = 1'b0;
    idle_like   = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          idle_like = 1'b1;
        end
        STALL: begin
          if (stall_cnt_q != '0) begin
            stall_cnt_d = stall_cnt_q - 1'b1;
          end else if (req_i) begin
            gnt_o  = 1'b1;
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_d = lat_cnt_q - 1'b1;
          end else begin
            rvalid_o  = 1'b1;
            idle_like = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (idle_like && req_i) begin
        if (stall_pick == '0) begin
          gnt_o  = 1'b1;
          accept = 1'b1;
        end else begin
          stall_cnt_d = stall_pick - 1'b1;
          state_d     = STALL;
        end
      end

      if (accept) begin
        state_d   = BUSY;
        lat_cnt_d = LatW'(ReadLatency - 1);
      end
    end
  end

  // Capture the response kind at the accept so it survives until rvalid.
  always_comb begin
    rsp_read_d = rsp_read_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      rsp_read_d = !we_i && in_range;
      rsp_err_d  = !in_range;
    end
  end

  // Control state registers; reset abandons any stall or pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_read_q  <= rsp_read_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Backing array: writes commit and reads launch at the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept && in_range && we_i) begin
      mem[widx] <= (mem[widx] & ~wmask) | (wdata_i & wmask);
    end
    if (accept && in_range && !we_i) begin
      mem_rdata_q <= mem[widx];
    end
  end

  assign rdata_o = (rvalid_o && rsp_read_q) ? mem_rdata_q : '0;
  assign err_o   = rvalid_o & rsp_err_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Randomised bench for mem_stall_responder with a timeline-level reference model.
module tb_mem_stall_responder;

  localparam int          Depth    = 1 << 20;
  localparam logic [31:0] Base     = 32'h80000000;
  localparam int          Lat      = 1;
  localparam int          MaxStall = 3;

  logic        clk = 1'b0;
  logic        rst_n, stall_en, req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  strb;

  logic        rst4_n, stall4, req4, we4, gnt4, rvalid4, err4;
  logic [31:0] addr4, wdata4, rdata4;
  logic [3:0]  strb4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stall_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en), .req_i(req), .gnt_o(gnt),
    .addr_i(addr), .we_i(we), .wdata_i(wdata), .strb_i(strb),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  mem_stall_responder #(.Depth(1024), .ReadLatency(4), .MaxStall(0)) dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .stall_en_i(stall4), .req_i(req4), .gnt_o(gnt4),
    .addr_i(addr4), .we_i(we4), .wdata_i(wdata4), .strb_i(strb4),
    .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4)
  );

  // Reference model: per-request grant cycle and response, plus word memory.
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] mem_m [int unsigned];
  logic [15:0] m_lfsr;
  int          ready_cyc;
  bit          have_cur;
  int          cur_g;
  int          cur_p;
  int          last_stall;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10));
    return v;
  endfunction

  function automatic void model_reset();
    rsp_q.delete();
    have_cur = 1'b0;
    m_lfsr   = 16'hACE1;
  endfunction

  function automatic void model_present(input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] s,
                                        input logic se);
    logic [31:0] off;
    int unsigned idx;
    logic        inr;
    int          e, g;
    logic [31:0] word;
    rsp_t        r;
    off = a - Base;
    idx = off >> 2;
    inr = idx < 32'(Depth);
    e = (cyc > ready_cyc) ? cyc : ready_cyc;
    last_stall = se ? (int'(m_lfsr & 16'h000F) % (MaxStall + 1)) : 0;
    g = e + last_stall;
    m_lfsr = model_step(m_lfsr);
    ready_cyc = g + Lat;
    r.due = g + Lat;
    r.err = !inr;
    r.rdata = 32'h0;
    if (inr) begin
      word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        mem_m[idx] = word;
      end else begin
        r.rdata = word;
      end
    end
    rsp_q.push_back(r);
    have_cur = 1'b1;
    cur_g = g;
    cur_p = cyc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Every cycle: compare the main DUT against the model timeline.
  always @(negedge clk) begin : compare_proc
    logic        eg, ev, ee;
    logic [31:0] ed;
    eg = have_cur && (cyc == cur_g);
    ev = 1'b0;
    ee = 1'b0;
    ed = 32'h0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      ev = 1'b1;
      ed = rsp_q[0].rdata;
      ee = rsp_q[0].err;
      void'(rsp_q.pop_front());
    end
    checkOutput("gnt", {31'b0, gnt}, {31'b0, eg});
    checkOutput("rvalid", {31'b0, rvalid}, {31'b0, ev});
    checkOutput("rdata", rdata, ed);
    checkOutput("err", {31'b0, err}, {31'b0, ee});
  end

  // Present one request, hold it until the model's grant cycle, then drop it.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output int delay);
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    model_present(w, a, d, s, stall_en);
    delay = -1;
    do begin
      @(negedge clk);
      if (gnt && delay < 0) delay = cyc - cur_p;
    end while (cyc < cur_g);
    @(posedge clk); #1;
    req = 1'b0;
    have_cur = 1'b0;
  endtask

  task automatic checkResponse(input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    checkOutput("lit_rvalid", {31'b0, rvalid}, 32'h1);
    checkOutput("lit_rdata", rdata, exp_d);
    checkOutput("lit_err", {31'b0, err}, {31'b0, exp_e});
    @(posedge clk); #1;
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    req   = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_cyc = cyc;
  endtask

  task automatic abortTxn(input logic [31:0] a, input int n);
    req = 1'b1; we = 1'b0; addr = a;
    model_present(1'b0, a, 32'h0, 4'h0, stall_en);
    repeat (n) @(posedge clk);
    #1;
    doReset(2);
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned pool [10];
    int unsigned sel;
    pool = '{0, 1, 2, 3, 4, 5, 6, 7, Depth - 2, Depth - 1};
    sel = $urandom_range(0, 9);
    if (sel < 8) return Base + 32'(pool[$urandom_range(0, 9)] << 2) + 32'($urandom_range(0, 3));
    else if (sel == 8) return Base - 32'(4 * $urandom_range(1, 16)) + 32'($urandom_range(0, 3));
    else return Base + 32'(4 * Depth) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int d;
    int exp_delay [6];
    int unsigned pool_idx [10];
    exp_delay = '{1, 0, 0, 0, 2, 3};
    pool_idx  = '{0, 1, 2, 3, 4, 5, 6, 7, Depth - 2, Depth - 1};

    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = Base + 32'h10; wdata = 32'h0; strb = 4'h0;
    stall_en = 1'b0;
    rst4_n = 1'b0; stall4 = 1'b0; req4 = 1'b1; we4 = 1'b1; addr4 = Base;
    wdata4 = 32'h12345678; strb4 = 4'hF;
    model_reset();
    ready_cyc = 0;

    $display("[TB] reset with request held");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_cyc = cyc;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, Base + 32'h10, 32'h0, 4'hF, d);
    checkOutput("first_gnt_delay", 32'(d), 32'h0);
    checkResponse(32'h0, 1'b0);
    applyStimulus(1'b1, Base + 32'h10, 32'hDEADBEEF, 4'b0101, d);
    checkResponse(32'h0, 1'b0);
    applyStimulus(1'b0, Base + 32'h10, 32'h0, 4'h0, d);
    checkResponse(32'h00AD00EF, 1'b0);
    applyStimulus(1'b1, Base, 32'hCAFEF00D, 4'hF, d);
    checkResponse(32'h0, 1'b0);
    applyStimulus(1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, d);
    checkResponse(32'h0, 1'b1);
    applyStimulus(1'b0, Base + 32'(4 * Depth), 32'h0, 4'h0, d);
    checkResponse(32'h0, 1'b1);
    applyStimulus(1'b1, Base + 32'(4 * Depth), 32'hFFFFFFFF, 4'hF, d);
    checkResponse(32'h0, 1'b1);
    applyStimulus(1'b0, Base, 32'h0, 4'h0, d);
    checkResponse(32'hCAFEF00D, 1'b0);
    applyStimulus(1'b1, Base + 32'(4 * (Depth - 1)), 32'h13579BDF, 4'hF, d);
    checkResponse(32'h0, 1'b0);
    applyStimulus(1'b0, Base + 32'(4 * (Depth - 1)) + 32'h3, 32'h0, 4'h0, d);
    checkResponse(32'h13579BDF, 1'b0);

    $display("[TB] randomised traffic");
    foreach (pool_idx[i]) applyStimulus(1'b1, Base + 32'(pool_idx[i] << 2), $urandom, 4'hF, d);
    for (int i = 0; i < 80; i++) begin
      stall_en = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] stall sequence from seed");
    stall_en = 1'b0;
    doReset(2);
    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, Base + 32'h10, 32'h0, 4'h0, d);
      if (i < 6) begin
        checkOutput($sformatf("model_stall_%0d", i), 32'(last_stall), 32'(exp_delay[i]));
        checkOutput($sformatf("dut_stall_%0d", i), 32'(d), 32'(exp_delay[i]));
      end else begin
        checkOutput($sformatf("stall_bound_%0d", i), {31'b0, (d >= 0 && d <= MaxStall)}, 32'h1);
      end
    end

    $display("[TB] reset during stall and busy");
    doReset(2);
    abortTxn(Base + 32'h10, 1);
    stall_en = 1'b0;
    abortTxn(Base + 32'h10, 1);
    stall_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, Base + 32'h10, 32'h0, 4'h0, d);
      checkOutput($sformatf("repeat_stall_%0d", i), 32'(d), 32'(exp_delay[i]));
    end
    stall_en = 1'b0;

    $display("[TB] latency-4 instance");
    rst4_n = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      checkOutput($sformatf("l4_gnt_%0d", k), {31'b0, gnt4}, {31'b0, (k % 4 == 0)});
      checkOutput($sformatf("l4_rvalid_%0d", k), {31'b0, rvalid4}, {31'b0, (k >= 4 && k % 4 == 0)});
      checkOutput($sformatf("l4_rdata_%0d", k), rdata4,
                  (k >= 8 && k % 4 == 0) ? 32'h12345678 : 32'h0);
      checkOutput($sformatf("l4_err_%0d", k), {31'b0, err4}, 32'h0);
      @(posedge clk); #1;
      if (k == 0) we4 = 1'b0;
    end
    req4 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
